// File: rtl/cluster_evt_reader_if.sv
// Bus bundle for one cluster reader: FWFT FIFO head, sync-engine status and
// command, and the forwarded word stream toward the merge output stage.
// The reader binds the slave modport; the FIFO/engine/merge side binds master.
interface cluster_evt_reader_if #(
    parameter int DATA_WIDTH   = 65,
    parameter int EVT_HDR_BITS = 40,
    parameter int ERR_CNT_BITS = 16
);
    logic [DATA_WIDTH-1:0]   fifo_dout;
    logic                    fifo_empty;
    logic                    fifo_rd_en;
    logic [1:0]              evt_available;
    logic [EVT_HDR_BITS-1:0] evt_l0id;
    logic [1:0]              evt_ctrl;
    logic [DATA_WIDTH-1:0]   out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic                    proto_err;
    logic [ERR_CNT_BITS-1:0] proto_err_cnt;

    modport slave (
        input  fifo_dout, fifo_empty, evt_ctrl, out_ready,
        output fifo_rd_en, evt_available, evt_l0id, out_data, out_valid,
               out_last, proto_err, proto_err_cnt
    );

    modport master (
        output fifo_dout, fifo_empty, evt_ctrl, out_ready,
        input  fifo_rd_en, evt_available, evt_l0id, out_data, out_valid,
               out_last, proto_err, proto_err_cnt
    );
endinterface

// File: rtl/cluster_evt_reader.sv
// Per-cluster event reader. Splits the FWFT cluster FIFO stream into event
// header / module / event footer segments, reports the segment type and the
// event L0ID to the sync engine, and executes the engine's WAIT/TX/DROP
// command word by word with zero latency.
//
// Module segments have no length field: a module word is the last one only
// when the word after it carries the control flag. To know that while the
// word is being handed out, the reader keeps the current module word in a
// one-word holding register and looks at the FIFO head as its successor.
// Header and footer segments are fixed length and are forwarded straight
// from the FIFO head.
//
// Optional build macro CLUSTER_EVT_READER_L0ID_CHECK_EN adds the sticky
// l0id_seq_err output and checks that consecutive headers carry L0ID+1.
module cluster_evt_reader #(
    parameter int DATA_WIDTH   = 65,
    parameter int EVT_HDR_BITS = 40,
    parameter int EHDR_WORDS   = 3,
    parameter int EFTR_WORDS   = 2,
    parameter int ERR_CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef CLUSTER_EVT_READER_L0ID_CHECK_EN
    output logic                l0id_seq_err,
`endif
    cluster_evt_reader_if.slave bus
);
    localparam int MAXW   = (EHDR_WORDS > EFTR_WORDS) ? EHDR_WORDS : EFTR_WORDS;
    localparam int WCNT_W = $clog2(MAXW + 1);

    localparam logic [7:0] MK_EHDR = 8'hAB;
    localparam logic [7:0] MK_MHDR = 8'h55;
    localparam logic [7:0] MK_EFTR = 8'hCD;

    localparam logic [1:0] CMD_TX   = 2'd1;
    localparam logic [1:0] CMD_DROP = 2'd2;

    localparam logic [1:0] AV_NONE = 2'd0;
    localparam logic [1:0] AV_HDR  = 2'd1;
    localparam logic [1:0] AV_MOD  = 2'd2;
    localparam logic [1:0] AV_FTR  = 2'd3;

    typedef enum logic [2:0] {
        S_SEEK = 3'd0,
        S_HDR  = 3'd1,
        S_MOD  = 3'd2,
        S_FTR  = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
    logic [DATA_WIDTH-1:0]   hld_q, hld_d;
    logic [EVT_HDR_BITS-1:0] l0id_q, l0id_d;
    logic                    err_q, err_d;
    logic [ERR_CNT_BITS-1:0] ecnt_q;

`ifdef CLUSTER_EVT_READER_L0ID_CHECK_EN
    logic                    have_prev_q, have_prev_d;
    logic                    seq_err_q, seq_err_d;
    logic [EVT_HDR_BITS-1:0] l0id_nxt;
    assign l0id_nxt = l0id_q + 1'b1;
`endif

    // Head word decode
    logic                    hd_flag;
    logic [7:0]              hd_mark;
    logic                    hd_ehdr, hd_mhdr, hd_eftr;
    logic [EVT_HDR_BITS-1:0] hd_l0id;
    logic                    hd_empty;

    assign hd_flag  = bus.fifo_dout[DATA_WIDTH-1];
    assign hd_mark  = bus.fifo_dout[DATA_WIDTH-2 -: 8];
    assign hd_ehdr  = hd_flag && (hd_mark == MK_EHDR);
    assign hd_mhdr  = hd_flag && (hd_mark == MK_MHDR);
    assign hd_eftr  = hd_flag && (hd_mark == MK_EFTR);
    assign hd_l0id  = bus.fifo_dout[EVT_HDR_BITS-1:0];
    assign hd_empty = bus.fifo_empty;

    // Command decode; code 3 behaves like WAIT
    logic is_tx, is_drop;
    assign is_tx   = (bus.evt_ctrl == CMD_TX);
    assign is_drop = (bus.evt_ctrl == CMD_DROP);

    // Segment length bookkeeping for fixed-length header/footer segments
    logic [WCNT_W-1:0] wcnt_inc, seg_len;
    logic              first_last;
    assign wcnt_inc   = wcnt_q + 1'b1;
    assign seg_len    = (state_q == S_FTR) ? WCNT_W'(EFTR_WORDS) : WCNT_W'(EHDR_WORDS);
    assign first_last = hd_ehdr ? (EHDR_WORDS == 1) : (EFTR_WORDS == 1);

    logic [1:0] avail;
    logic       rd_en, oval, olast, seg_last, mod_done;

    // Segment parser and command execution: next state plus the zero-latency handshake
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        hld_d    = hld_q;
        l0id_d   = l0id_q;
        err_d    = 1'b0;
        avail    = AV_NONE;
        rd_en    = 1'b0;
        oval     = 1'b0;
        olast    = 1'b0;
        seg_last = 1'b0;
        mod_done = 1'b0;
`ifdef CLUSTER_EVT_READER_L0ID_CHECK_EN
        have_prev_d = have_prev_q;
        seq_err_d   = seq_err_q;
`endif
        if (rst_n) begin
            case (state_q)
                S_SEEK: begin
                    if (!hd_empty) begin
                        if (hd_ehdr || hd_eftr) begin
                            avail    = hd_ehdr ? AV_HDR : AV_FTR;
                            seg_last = first_last;
                            oval     = is_tx;
                            olast    = is_tx && seg_last;
                            rd_en    = is_tx ? bus.out_ready : is_drop;
                            if (rd_en) begin
                                wcnt_d  = WCNT_W'(1);
                                state_d = seg_last ? S_GAP : (hd_ehdr ? S_HDR : S_FTR);
                                if (hd_ehdr) begin
                                    l0id_d = hd_l0id;
                                    if (hd_l0id == '0) err_d = 1'b1;
`ifdef CLUSTER_EVT_READER_L0ID_CHECK_EN
                                    if (have_prev_q && (hd_l0id != l0id_nxt)) begin
                                        seq_err_d = 1'b1;
                                        err_d     = 1'b1;
                                    end
                                    have_prev_d = 1'b1;
`endif
                                end
                            end
                        end else if (hd_mhdr) begin
                            // Module header moves into the holding register; it is
                            // handed out once its successor is visible.
                            avail = AV_MOD;
                            rd_en = is_tx || is_drop;
                            if (rd_en) begin
                                hld_d   = bus.fifo_dout;
                                state_d = S_MOD;
                            end
                        end else begin
                            // Stray DATA or unknown control word outside any segment
                            rd_en = 1'b1;
                            err_d = 1'b1;
                        end
                    end
                end
                S_HDR, S_FTR: begin
                    avail = (state_q == S_HDR) ? AV_HDR : AV_FTR;
                    if (!hd_empty) begin
                        if (hd_flag) begin
                            // Segment cut short by a control word; leave it at the head
                            err_d   = 1'b1;
                            state_d = S_GAP;
                        end else begin
                            seg_last = (wcnt_inc == seg_len);
                            oval     = is_tx;
                            olast    = is_tx && seg_last;
                            rd_en    = is_tx ? bus.out_ready : is_drop;
                            if (rd_en) begin
                                wcnt_d = wcnt_inc;
                                if (seg_last) state_d = S_GAP;
                            end
                        end
                    end
                end
                S_MOD: begin
                    avail = AV_MOD;
                    // The held word's fate needs its successor, so an empty head waits
                    if (!hd_empty) begin
                        oval     = is_tx;
                        olast    = is_tx && hd_flag;
                        mod_done = is_tx ? bus.out_ready : is_drop;
                        if (mod_done) begin
                            if (hd_flag) begin
                                state_d = S_GAP;
                            end else begin
                                rd_en = 1'b1;
                                hld_d = bus.fifo_dout;
                            end
                        end
                    end
                end
                S_GAP: begin
                    state_d = S_SEEK;
                end
                default: begin
                    state_d = S_SEEK;
                end
            endcase
        end
    end

    // State, counters, L0ID and the registered error pulse/count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_SEEK;
            wcnt_q  <= '0;
            hld_q   <= '0;
            l0id_q  <= '0;
            err_q   <= 1'b0;
            ecnt_q  <= '0;
`ifdef CLUSTER_EVT_READER_L0ID_CHECK_EN
            have_prev_q <= 1'b0;
            seq_err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            hld_q   <= hld_d;
            l0id_q  <= l0id_d;
            err_q   <= err_d;
            if (err_d && (ecnt_q != '1)) ecnt_q <= ecnt_q + 1'b1;
`ifdef CLUSTER_EVT_READER_L0ID_CHECK_EN
            have_prev_q <= have_prev_d;
            seq_err_q   <= seq_err_d;
`endif
        end
    end

    assign bus.fifo_rd_en    = rd_en;
    assign bus.evt_available = avail;
    assign bus.evt_l0id      = l0id_q;
    assign bus.out_valid     = oval;
    assign bus.out_last      = olast;
    assign bus.out_data      = (state_q == S_MOD) ? hld_q : bus.fifo_dout;
    assign bus.proto_err     = err_q;
    assign bus.proto_err_cnt = ecnt_q;
`ifdef CLUSTER_EVT_READER_L0ID_CHECK_EN
    assign l0id_seq_err      = seq_err_q;
`endif
endmodule

// File: tb/tb_cluster_evt_reader.sv
// Directed bench for cluster_evt_reader. A queue stands in for the FWFT
// FIFO; a stream-level model parses the pushed words into segments and
// predicts the forwarded words, segment types and error count, which are
// compared against the DUT every cycle.
module tb_cluster_evt_reader;
    localparam int DW  = 65;
    localparam int EHB = 40;
    localparam int ECB = 16;
    localparam int NH  = 3;
    localparam int NF  = 2;
    localparam logic [1:0] TX = 2'd1, DROP = 2'd2;

    logic clk = 1'b0;
    logic rst_n;
`ifdef CLUSTER_EVT_READER_L0ID_CHECK_EN
    logic l0id_seq_err;
`endif

    always #10 clk = ~clk;

    cluster_evt_reader_if #(.DATA_WIDTH(DW), .EVT_HDR_BITS(EHB), .ERR_CNT_BITS(ECB)) bus ();

    cluster_evt_reader #(
        .DATA_WIDTH(DW), .EVT_HDR_BITS(EHB), .EHDR_WORDS(NH), .EFTR_WORDS(NF), .ERR_CNT_BITS(ECB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef CLUSTER_EVT_READER_L0ID_CHECK_EN
        .l0id_seq_err(l0id_seq_err),
`endif
        .bus(bus)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          last;
    } ow_t;

    int n_chk = 0, n_fail = 0;
    logic [DW-1:0] fq[$];    // FIFO contents seen by the DUT
    logic [DW-1:0] pend[$];  // words not yet loaded into the FIFO
    logic [DW-1:0] ms[$];    // words awaiting the model
    ow_t           exp_q[$];
    int            exp_seg[$];
    int            exp_err, seen_err, n_out, prev_av;
    int            avail_log[$];
    logic [31:0]   last_mask;
    logic [1:0]    ctl_t [4];
    logic          have_prev_m, exp_seq;
    logic [EHB-1:0] prev_m;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] cw(input logic [7:0] m, input logic [EHB-1:0] l);
        logic [DW-1:0] w;
        w = '0;
        w[DW-1] = 1'b1;
        w[DW-2 -: 8] = m;
        w[EHB-1:0] = l;
        return w;
    endfunction

    function automatic logic [DW-1:0] dat(input logic [31:0] x);
        logic [DW-1:0] w;
        w = '0;
        w[31:0] = x;
        return w;
    endfunction

    task automatic emit(input logic [DW-1:0] w, input logic l, input bit tx);
        if (tx) exp_q.push_back('{d: w, last: l});
    endtask

    // Stream-level model: walk the word list, carve segments by marker and length
    task automatic model_run();
        int i, j, k, n, t, len;
        logic [DW-1:0] w;
        logic [7:0] m;
        logic [EHB-1:0] l, nx;
        logic bad;
        i = 0;
        n = ms.size();
        while (i < n) begin
            w = ms[i];
            m = w[DW-2 -: 8];
            if (!w[DW-1] || !(m == 8'hAB || m == 8'h55 || m == 8'hCD)) begin
                exp_err++;
                i++;
            end else if (m == 8'h55) begin
                exp_seg.push_back(2);
                j = i + 1;
                while (j < n && !ms[j][DW-1]) j++;
                for (int q = i; q < j; q++) emit(ms[q], (q == j - 1) && (j < n), ctl_t[2] == TX);
                i = j;
            end else begin
                t   = (m == 8'hAB) ? 1 : 3;
                len = (t == 1) ? NH : NF;
                exp_seg.push_back(t);
                if (t == 1) begin
                    l   = w[EHB-1:0];
                    bad = (l == '0);
`ifdef CLUSTER_EVT_READER_L0ID_CHECK_EN
                    nx = prev_m + 1'b1;
                    if (have_prev_m && l != nx) begin
                        bad = 1'b1;
                        exp_seq = 1'b1;
                    end
`endif
                    nx = l;
                    have_prev_m = 1'b1;
                    prev_m = nx;
                    if (bad) exp_err++;
                end
                emit(w, len == 1, ctl_t[t] == TX);
                k = 1;
                i++;
                while (k < len && i < n && !ms[i][DW-1]) begin
                    emit(ms[i], k == len - 1, ctl_t[t] == TX);
                    k++;
                    i++;
                end
                if (k < len && i < n) exp_err++;
            end
        end
        ms.delete();
    endtask

    task automatic add(input logic [DW-1:0] w);
        ms.push_back(w);
        pend.push_back(w);
    endtask

    task automatic drive();
        bus.fifo_empty = (fq.size() == 0);
        bus.fifo_dout  = (fq.size() != 0) ? fq[0] : '0;
        #1;
        bus.evt_ctrl = ctl_t[bus.evt_available];
        #1;
    endtask

    task automatic feed(input int k);
        for (int i = 0; i < k && pend.size() != 0; i++) fq.push_back(pend.pop_front());
        drive();
    endtask

    // Per-cycle comparison of DUT outputs against the model
    task automatic compare_cycle();
        if (!rst_n) begin
            seen_err = 0; n_out = 0; prev_av = 0; last_mask = '0;
            avail_log.delete();
            return;
        end
        if (bus.fifo_empty) chk("rd_on_empty", bus.fifo_rd_en, 1'b0);
        if (bus.out_valid) begin
            chk("valid_needs_tx", bus.evt_ctrl, TX);
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL sb_extra: got word %0h expected none", bus.out_data);
            end else begin
                chk("sb_data", bus.out_data, exp_q[0].d);
                chk("sb_last", bus.out_last, exp_q[0].last);
                if (bus.out_ready) begin
                    if (bus.out_last && n_out < 32) last_mask[n_out] = 1'b1;
                    n_out++;
                    void'(exp_q.pop_front());
                end
            end
        end
        if (int'(bus.evt_available) != prev_av) begin
            avail_log.push_back(int'(bus.evt_available));
            if (prev_av != 0 && bus.evt_available != 0) begin
                n_chk++; n_fail++;
                $display("FAIL avail_gap: got %0d after %0d expected 0 between", bus.evt_available, prev_av);
            end
            if (bus.evt_available != 0) begin
                if (exp_seg.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL seg_type: got %0d expected no segment", bus.evt_available);
                end else begin
                    chk("seg_type", bus.evt_available, exp_seg.pop_front());
                end
            end
            prev_av = int'(bus.evt_available);
        end
        if (bus.proto_err) seen_err++;
    endtask

    task automatic cyc();
        logic pop;
        @(negedge clk);
        compare_cycle();
        pop = bus.fifo_rd_en;
        @(posedge clk);
        #1;
        if (pop && fq.size() != 0) void'(fq.pop_front());
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset(input bit keep);
        rst_n = 1'b0;
        if (!keep) fq.delete();
        pend.delete();
        ms.delete();
        drive();
        cyc();
        chk("rst_avail", bus.evt_available, 2'd0);
        chk("rst_l0id", bus.evt_l0id, '0);
        chk("rst_err", bus.proto_err, 1'b0);
        chk("rst_cnt", bus.proto_err_cnt, '0);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_rd", bus.fifo_rd_en, 1'b0);
        chk("rst_last", bus.out_last, 1'b0);
        rst_n = 1'b1;
        exp_q.delete();
        exp_seg.delete();
        exp_err = 0;
        have_prev_m = 1'b0;
        exp_seq = 1'b0;
        drive();
    endtask

    task automatic end_chk(input string nm);
        chk({nm, "_sb_left"}, exp_q.size(), 0);
        chk({nm, "_seg_left"}, exp_seg.size(), 0);
        chk({nm, "_errs"}, seen_err, exp_err);
    endtask

    task automatic push_event(input logic [EHB-1:0] l0id, input int nd);
        add(cw(8'hAB, l0id)); add(dat(32'h100)); add(dat(32'h101));
        add(cw(8'h55, 40'h1));
        for (int i = 0; i < nd; i++) add(dat(32'h200 + i));
        add(cw(8'hCD, 40'h0)); add(dat(32'h300));
    endtask

    initial begin
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) ctl_t[i] = TX;
        exp_err = 0; seen_err = 0; n_out = 0; prev_av = 0; last_mask = '0;
        have_prev_m = 1'b0; exp_seq = 1'b0; prev_m = '0;
        drive();
        run(2);
        do_reset(0);

        // 1: full event, TX throughout
        push_event(40'h12, 4);
        model_run();
        feed(10);
        run(25);
        chk("t1_l0id", bus.evt_l0id, 40'h12);
        chk("t1_nout", n_out, 10);
        chk("t1_last_pos", last_mask, 32'h0000_0284);
        chk("t1_log_len", avail_log.size(), 6);
        if (avail_log.size() == 6) begin
            int exp_log [6] = '{1, 0, 2, 0, 3, 0};
            for (int i = 0; i < 6; i++) chk("t1_avail_seq", avail_log[i], exp_log[i]);
        end
        end_chk("t1");

        // 2: header/footer dropped, module forwarded
        do_reset(0);
        ctl_t[1] = DROP; ctl_t[3] = DROP;
        push_event(40'h12, 4);
        model_run();
        feed(10);
        run(25);
        chk("t2_nout", n_out, 5);
        chk("t2_drained", fq.size(), 0);
        chk("t2_no_err", bus.proto_err_cnt, '0);
        end_chk("t2");
        ctl_t[1] = TX; ctl_t[3] = TX;

        // 3: module stalls on an empty FIFO
        do_reset(0);
        add(cw(8'h55, 40'h2)); add(dat(32'hA1)); add(dat(32'hA2));
        add(cw(8'hCD, 40'h0)); add(dat(32'hA3));
        model_run();
        feed(2);
        run(3);
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_avail", bus.evt_available, 2'd2);
            chk("t3_stall_valid", bus.out_valid, 1'b0);
            cyc();
        end
        feed(3);
        run(12);
        chk("t3_nout", n_out, 5);
        chk("t3_last_pos", last_mask, 32'h0000_0014);
        end_chk("t3");

        // 4: downstream backpressure mid-header
        do_reset(0);
        add(cw(8'hAB, 40'h33)); add(dat(32'hB1)); add(dat(32'hB2));
        model_run();
        feed(3);
        cyc();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_rd_held", bus.fifo_rd_en, 1'b0);
            chk("t4_valid", bus.out_valid, 1'b1);
            chk("t4_data_stable", bus.out_data, dat(32'hB1));
            cyc();
        end
        bus.out_ready = 1'b1;
        run(8);
        chk("t4_nout", n_out, 3);
        chk("t4_drained", fq.size(), 0);
        end_chk("t4");

        // 5: stray words before a header, then a header with L0ID 0
        do_reset(0);
        add(dat(32'h1)); add(dat(32'h2)); add(cw(8'h77, 40'h0));
        model_run();
        feed(3);
        run(6);
        chk("t5_cnt3", bus.proto_err_cnt, 16'd3);
        chk("t5_avail_idle", bus.evt_available, 2'd0);
        add(cw(8'hAB, 40'h0)); add(dat(32'hC1)); add(dat(32'hC2));
        model_run();
        feed(3);
        run(8);
        chk("t5_cnt4", bus.proto_err_cnt, 16'd4);
        chk("t5_l0id0", bus.evt_l0id, 40'h0);
        end_chk("t5");

        // 6: reset in the middle of a module segment
        do_reset(0);
        add(cw(8'hAB, 40'h5)); add(dat(32'hD0)); add(dat(32'hD1));
        add(cw(8'h55, 40'h3)); add(dat(32'hD2));
        model_run();
        feed(5);
        run(8);
        chk("t6_in_mod", bus.evt_available, 2'd2);
        chk("t6_l0id5", bus.evt_l0id, 40'h5);
        fq.push_back(dat(32'hD3));
        fq.push_back(dat(32'hD4));
        do_reset(1);
        chk("t6_kept", fq.size(), 2);
        ms.push_back(dat(32'hD3));
        ms.push_back(dat(32'hD4));
        model_run();
        run(5);
        chk("t6_cnt2", bus.proto_err_cnt, 16'd2);
        add(cw(8'hAB, 40'h7)); add(dat(32'hE0)); add(dat(32'hE1));
        add(cw(8'hCD, 40'h0)); add(dat(32'hE2));
        model_run();
        feed(5);
        run(14);
        chk("t6_l0id7", bus.evt_l0id, 40'h7);
        chk("t6_cnt_after", bus.proto_err_cnt, 16'd2);
        end_chk("t6");

`ifdef CLUSTER_EVT_READER_L0ID_CHECK_EN
        // L0ID sequence: 5 then 7 is a skip
        do_reset(0);
        add(cw(8'hAB, 40'h5)); add(dat(32'hF0)); add(dat(32'hF1));
        add(cw(8'hAB, 40'h7)); add(dat(32'hF2)); add(dat(32'hF3));
        model_run();
        feed(6);
        run(14);
        chk("seq_err_set", l0id_seq_err, 1'b1);
        chk("seq_model", exp_seq, 1'b1);
        chk("seq_cnt", bus.proto_err_cnt, 16'd1);
        end_chk("seq");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cluster_evt_reader.md
Name: cluster_evt_reader

Overview:
- Per-cluster front end that sits directly upstream of the cluster synchronisation engine; one instance per cluster FIFO.
- Parses the first-word-fall-through cluster FIFO head into event segments: event header, module, event footer.
- Reports the segment type and the event L0ID to the sync engine.
- Executes the engine's per-cluster WAIT/TX/DROP command, either forwarding words to the merge output stage or discarding them.

Parameters:
- DATA_WIDTH, 65, FIFO word width; bit DATA_WIDTH-1 is the control flag.
- EVT_HDR_BITS, 40, L0ID width; L0ID is taken from header word 0 bits [EVT_HDR_BITS-1:0].
- EHDR_WORDS, 3, words in an event header segment (≥1).
- EFTR_WORDS, 2, words in an event footer segment (≥1).
- ERR_CNT_BITS, 16, protocol error counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- fifo_dout  in  DATA_WIDTH  FWFT FIFO head word
- fifo_empty  in  1  FIFO empty
- fifo_rd_en  out  1  pop FIFO head
- evt_available  out  2  0=none, 1=header, 2=module, 3=footer
- evt_l0id  out  EVT_HDR_BITS  L0ID of the current event
- evt_ctrl  in  2  0=WAIT, 1=TX, 2=DROP, 3=treated as WAIT
- out_data  out  DATA_WIDTH  forwarded word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_last  out  1  out_data is the last word of its segment
- proto_err  out  1  one-cycle error pulse
- proto_err_cnt  out  ERR_CNT_BITS  saturating error count

Behaviour:
Word classes (flag = bit DATA_WIDTH-1, marker = bits [DATA_WIDTH-2:DATA_WIDTH-9]):
- EHDR_START: flag=1, marker=0xAB.
- MHDR: flag=1, marker=0x55.
- EFTR_START: flag=1, marker=0xCD.
- DATA: flag=0.
- Any other flag=1 word is UNKNOWN.

State machine SEEK, HDR, MOD, FTR, GAP; reset state SEEK.

SEEK
- If fifo_empty: evt_available=0.
- Otherwise, by head word class: EHDR_START→1, MHDR→2, EFTR_START→3.
- DATA or UNKNOWN at head: evt_available=0; the word is popped and discarded in this cycle, proto_err pulses, and the state stays SEEK.
- Popping the first word of a valid segment enters HDR/MOD/FTR with word counter wcnt=1. If that word is also the segment's last, go directly to GAP.

HDR/MOD/FTR
- evt_available holds the segment type even while fifo_empty. The engine relies on a stalled segment remaining flagged.
- HDR and FTR end when wcnt reaches EHDR_WORDS or EFTR_WORDS.
- MOD ends on the popped word whose successor is a flag=1 word. The successor is visible at the FWFT head when the pop occurs.
- If MOD is the state and the head is empty, no end is decided; wait.
- Popping the last word goes to GAP.
- In HDR/FTR, a flag=1 head before the count completes: proto_err, and the segment ends without popping (→GAP).

GAP
- evt_available=0 and no pop for exactly one cycle, then SEEK.
- This guarantees the engine sees available deassert between segments.

Command execution (combinational, zero latency, only in SEEK-with-valid-head/HDR/MOD/FTR):
- TX: out_valid = !fifo_empty; out_data = fifo_dout; fifo_rd_en = out_valid & out_ready.
- DROP: out_valid=0; fifo_rd_en = !fifo_empty.
- WAIT: no pop, out_valid=0.
- out_last=1 with the word that ends the segment.
- evt_ctrl may change between words; each popped word obeys the command in its own cycle.

evt_l0id
- Registered from header word 0 bits [EVT_HDR_BITS-1:0] on the cycle EHDR_START is popped.
- Held until the next header; reset 0.
- Header with L0ID 0 (reserved as idle by the engine): proto_err pulses, and the value 0 is still latched.

proto_err_cnt
- Increments per proto_err and saturates at all-ones.

Reset values:
- state=SEEK.
- evt_available=0, evt_l0id=0, proto_err=0, proto_err_cnt=0.
- out_valid=0, fifo_rd_en=0, out_last=0.
- A reset mid-segment abandons the segment; the remainder is parsed from SEEK and yields proto_err per stray word.

Optional Feature:
CLUSTER_EVT_READER_L0ID_CHECK_EN
- Defined: adds output l0id_seq_err (1 bit, sticky until reset) and a registered previous L0ID.
- Each latched header L0ID after the first must equal previous+1 (mod 2^EVT_HDR_BITS). Otherwise l0id_seq_err sets and proto_err pulses.
- Undefined: no port, no check logic.

Test Plan:
1. Push header(L0ID=0x12), MHDR+4 DATA, footer; evt_ctrl=TX throughout, out_ready=1 → 3+5+2 words out in order; evt_available sequence 1,0(GAP),2,0,3,0; evt_l0id=0x12; out_last on words 3, 8, 10.
2. Same event with evt_ctrl=DROP for header and footer, TX for module → only 5 module words forwarded; FIFO fully drained; proto_err never asserted.
3. Module of 3 words, FIFO empties after word 2 for 5 cycles under TX → evt_available stays 2 with out_valid=0 through the stall; resumes; out_last on word 3.
4. out_ready held 0 for 4 cycles mid-header under TX → fifo_rd_en=0, out_data stable at the head word; no word lost or duplicated.
5. Two DATA words, then an UNKNOWN word (marker 0x77), before a header → 3 proto_err pulses, proto_err_cnt=3, evt_available=0 until the header reaches the head; header with L0ID=0 → proto_err_cnt=4.
6. rst_n low for 1 cycle mid-module → all outputs at reset values next cycle; remaining 2 DATA words give proto_err_cnt=2; next header parses normally. With the macro defined, L0IDs 5 then 7 → l0id_seq_err=1.
